// File: rtl/num_conv_pkg.sv
// Shared definitions for the MIX NUM character-to-binary converter.
//   WORD_W  : magnitude width of a MIX word (five 6-bit bytes)
//   BYTE_W  : MIX byte width (binary MIX, b = 64)
//   NDIGITS : digits converted from rA:rX, derived from WORD_W/BYTE_W
//   state_t : converter FSM states
package num_conv_pkg;

  localparam int WORD_W  = 30;
  localparam int BYTE_W  = 6;
  localparam int NDIGITS = 2 * WORD_W / BYTE_W;
  localparam int SH_W    = 2 * WORD_W;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/num_conv_mod10_6.sv
// Combinational 6-bit byte -> decimal digit (byte mod 10).
// Ports:
//   i_byte  in  BYTE_W  MIX byte, any value 0..63
//   o_digit out 4       byte mod 10, range 0..9
// Implemented as a subtract chain: removing 40, then 20, then 10 (each only
// when it fits) reduces any 0..63 value to 0..9 in three compare stages.
module num_conv_mod10_6
  import num_conv_pkg::*;
(
  input  logic [BYTE_W-1:0] i_byte,
  output logic [3:0]        o_digit
);

  logic [BYTE_W-1:0] w_s40;
  logic [BYTE_W-1:0] w_s20;
  logic [BYTE_W-1:0] w_s10;

  always_comb begin
    w_s40   = (i_byte >= 6'd40) ? (i_byte - 6'd40) : i_byte;  // 0..39
    w_s20   = (w_s40  >= 6'd20) ? (w_s40  - 6'd20) : w_s40;   // 0..19
    w_s10   = (w_s20  >= 6'd10) ? (w_s20  - 6'd10) : w_s20;   // 0..9
    o_digit = w_s10[3:0];
  end

endmodule

// File: rtl/num_conv.sv
// MIX NUM converter: turns the ten bytes of rA:rX into a binary magnitude,
// one digit per clock (acc <= acc*10 + digit), most significant byte first.
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active high
//   start     in   1       conversion request, sampled only in IDLE
//   a_in      in   WORD_W  rA magnitude, bits [29:24] = most significant digit
//   x_in      in   WORD_W  rX magnitude, bits [5:0] = least significant digit
//   busy      out  1       high while digits are being accumulated
//   done      out  1       one-cycle pulse when result/overflow are updated
//   result    out  WORD_W  converted value mod 2^WORD_W, held until next done
//   overflow  out  1       converted value did not fit in WORD_W bits
module num_conv
  import num_conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] x_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              overflow
);

  state_t            r_state;
  logic [SH_W-1:0]   r_sh;
  logic [WORD_W-1:0] r_acc;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [WORD_W-1:0] r_result;
  logic              r_overflow;

  logic [3:0]        w_digit;
  logic [WORD_W+3:0] w_acc_ext;
  logic [WORD_W+3:0] w_t;
  logic              w_carry;
  logic              w_last;

  num_conv_mod10_6 u_mod10 (
    .i_byte  (r_sh[SH_W-1 -: BYTE_W]),
    .o_digit (w_digit)
  );

  // acc*10 + d with four guard bits; anything landing in the guard bits
  // means the running value has exceeded the word. Truncating acc each step
  // keeps the low bits exact, so the final result is the true value mod 2^W.
  assign w_acc_ext = {4'd0, r_acc};
  assign w_t       = (w_acc_ext << 3) + (w_acc_ext << 1)
                   + {{WORD_W{1'b0}}, w_digit};
  assign w_carry   = |w_t[WORD_W+3:WORD_W];
  assign w_last    = (r_cnt == CNT_W'(NDIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sh       <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sh    <= {a_in, x_in};
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_acc <= w_t[WORD_W-1:0];
          r_ovf <= r_ovf | w_carry;
          r_sh  <= r_sh << BYTE_W;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // Outputs are loaded straight from the final step so the
            // visible result never shows a partial accumulation.
            r_result   <= w_t[WORD_W-1:0];
            r_overflow <= r_ovf | w_carry;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_num_conv.sv
// Self-checking bench for num_conv: stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on every done pulse.
module tb_num_conv;
  import num_conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] a_in;
  logic [29:0] x_in;
  logic        busy;
  logic        done;
  logic [29:0] result;
  logic        overflow;

  num_conv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .x_in     (x_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [29:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [29:0] last_res = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: read the ten bytes as decimal digits, form the number with
  // plain 64-bit arithmetic, then reduce to the word.
  function automatic void model(input logic [29:0] a, input logic [29:0] x,
                                output logic [29:0] res, output logic ovf);
    logic [59:0]     sh;
    longint unsigned v;
    int              b;
    sh = {a, x};
    v  = 0;
    for (int i = 0; i < 10; i++) begin
      b = int'(sh[59 - 6*i -: 6]);
      v = v * 10 + longint'(b % 10);
    end
    res = v[29:0];
    ovf = (v >= (64'd1 << 30));
  endfunction

  // Encode a decimal number as ten bytes, optionally with random "zone"
  // offsets (digit + 10k stays <= 63) so the mod-10 path is exercised.
  function automatic logic [59:0] from_decimal(longint unsigned n, bit zone);
    logic [59:0] sh;
    int          d;
    sh = '0;
    for (int i = 0; i < 10; i++) begin
      d = int'(n % 10);
      n = n / 10;
      if (zone) d = d + 10 * int'($urandom_range(0, (63 - d) / 10));
      sh[6*i +: 6] = 6'(d);
    end
    return sh;
  endfunction

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", longint'(result), longint'(mon_e.res));
        check("overflow", longint'(overflow), longint'(mon_e.ovf));
        check("done_cycle", longint'(cyc), longint'(mon_e.cyc));
        check("busy_at_done", longint'(busy), 0);
        last_res = mon_e.res;
      end
    end
  end

  task automatic start_conv(input logic [29:0] a, input logic [29:0] x, input bit push);
    logic [29:0] r;
    logic        o;
    @(negedge clk);
    a_in  = a;
    x_in  = x;
    start = 1'b1;
    if (push) begin
      model(a, x, r, o);
      sb.push_back('{res: r, ovf: o, cyc: cyc + 11});
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    check("result_held", longint'(result), longint'(last_res));
    $display("start a=%h x=%h push=%0d cycle=%0d", a, x, push, cyc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_one(input logic [59:0] sh);
    start_conv(sh[59:30], sh[29:0], 1'b1);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [59:0] sh;
    int          n0;
    int          seen;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    x_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_result", longint'(result), 0);
    check("reset_overflow", longint'(overflow), 0);
    rst = 1'b0;

    // Directed values
    run_one({30'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd2});          // 12
    run_one({10{6'd30}});                                    // 0
    run_one({10{6'd39}});                                    // 9999999999
    run_one(from_decimal(64'd1073741823, 1'b0));             // max fit
    run_one(from_decimal(64'd1073741824, 1'b0));             // wraps to 0
    run_one({30'd0, 6'd0, 6'd0, 6'd63, 6'd50, 6'd41});       // 301

    // Reset during RUN: no done, outputs cleared, then a clean conversion
    start_conv(30'h12345678, 30'h0ABCDEF0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", longint'(busy), 0);
    check("midrun_rst_done", longint'(done), 0);
    check("midrun_rst_result", longint'(result), 0);
    check("midrun_rst_overflow", longint'(overflow), 0);
    rst      = 1'b0;
    last_res = '0;
    repeat (15) @(negedge clk);
    run_one(from_decimal(64'd987654321, 1'b1));

    // start while busy and on the DONE cycle is ignored
    start_conv(30'h01234567, 30'h02345678, 1'b1);
    repeat (3) @(negedge clk);
    start_conv(30'h3FFFFFFF, 30'h3FFFFFFF, 1'b0);
    seen = 0;
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    if (done) seen = 1;
    check("done_seen", longint'(seen), 1);
    a_in  = 30'h15555555;
    x_in  = 30'h2AAAAAAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_ignored", longint'(busy), 0);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", longint'(sb.size()), 0);

    // start held high: a new conversion every 12 cycles
    sh = from_decimal(64'd5555555555, 1'b1);
    begin
      logic [29:0] r;
      logic        o;
      @(negedge clk);
      a_in  = sh[59:30];
      x_in  = sh[29:0];
      start = 1'b1;
      n0    = cyc;
      model(sh[59:30], sh[29:0], r, o);
      sb.push_back('{res: r, ovf: o, cyc: n0 + 11});
      sb.push_back('{res: r, ovf: o, cyc: n0 + 23});
      sb.push_back('{res: r, ovf: o, cyc: n0 + 35});
      repeat (30) @(negedge clk);
      start = 1'b0;
      $display("back-to-back a=%h x=%h from cycle %0d", sh[59:30], sh[29:0], n0);
      wait_drain();
      repeat (15) @(negedge clk);
    end

    // Randomized conversions
    for (int k = 0; k < 30; k++) begin
      case (k % 3)
        0:       sh = {6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                       6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                       6'($urandom), 6'($urandom)};
        1:       sh = from_decimal(64'd1073741800 + 64'($urandom_range(0, 48)), 1'b1);
        default: sh = from_decimal((64'($urandom) * 3) % 64'd10000000000, 1'b1);
      endcase
      run_one(sh);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
